// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM timebase controller.
package pwm_pkg;

    localparam int unsigned CNT_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } pwm_state_e;

    typedef enum logic {
        StopImmediate   = 1'b0,
        StopEndOfPeriod = 1'b1
    } stop_mode_e;

endpackage

// File: rtl/pwm_timebase_ctrl_if.sv
// Control/status bundle between the register file, prescaler and timebase controller.
interface pwm_timebase_ctrl_if import pwm_pkg::*; #(
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
);
    logic                 cen_req_i;
    logic                 stop_mode_i;
    logic                 opm_i;
    logic                 arpe_i;
    logic                 udis_i;
    logic                 ug_i;
    logic [CNT_WIDTH-1:0] arr_preload_i;
    logic                 uif_clr_i;
    logic                 ck_cnt_i;
    logic                 cen_o;
    logic                 update_event_o;
    logic [CNT_WIDTH-1:0] cnt_o;
    logic [CNT_WIDTH-1:0] arr_active_o;
    logic                 uif_o;
    logic                 busy_o;

    modport master (
        output cen_req_i, stop_mode_i, opm_i, arpe_i, udis_i, ug_i, arr_preload_i,
        output uif_clr_i, ck_cnt_i,
        input  cen_o, update_event_o, cnt_o, arr_active_o, uif_o, busy_o
    );

    modport slave (
        input  cen_req_i, stop_mode_i, opm_i, arpe_i, udis_i, ug_i, arr_preload_i,
        input  uif_clr_i, ck_cnt_i,
        output cen_o, update_event_o, cnt_o, arr_active_o, uif_o, busy_o
    );

endinterface

// File: rtl/pwm_period_counter.sv
// Period counter with >= overflow compare and ARR shadow register.
module pwm_period_counter import pwm_pkg::*; #(
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk_psc_i,
    input  logic                 rst_n_i,
    input  logic                 run_i,
    input  logic                 clr_i,
    input  logic                 ck_cnt_i,
    input  logic                 ug_i,
    input  logic                 udis_i,
    input  logic                 arpe_i,
    input  logic [CNT_WIDTH-1:0] arr_preload_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic [CNT_WIDTH-1:0] arr_active_o,
    output logic                 overflow_o,
    output logic                 uev_next_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] arr_q, arr_d;

    // >= lets an ARR lowered below the current count wrap on the next tick.
    assign overflow_o = run_i && ck_cnt_i && (cnt_q >= arr_q);
    assign uev_next_o = (overflow_o && !udis_i) || ug_i;

    always_comb begin
        cnt_d = cnt_q;
        if (ug_i || !run_i || clr_i || overflow_o) begin
            cnt_d = '0;
        end else if (ck_cnt_i) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // While stopped the shadow tracks the preload, like the prescaler reload rule.
    always_comb begin
        arr_d = arr_q;
        if (!run_i || !arpe_i || uev_next_o) begin
            arr_d = arr_preload_i;
        end
    end

    always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            arr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            arr_q <= arr_d;
        end
    end

    assign cnt_o        = cnt_q;
    assign arr_active_o = arr_q;

endmodule

// File: rtl/pwm_timebase_ctrl.sv
// PWM timebase sequencer: run/stop/one-pulse FSM, update event and flag generation.
module pwm_timebase_ctrl import pwm_pkg::*; #(
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                clk_psc_i,
    input  logic                rst_n_i,
    pwm_timebase_ctrl_if.slave  bus
);

    pwm_state_e state_q, state_d;
    logic       opm_lock_q, opm_lock_d;
    logic       uev_q, uif_q, uif_d;
    logic       running, cnt_clr, overflow, uev_next;

    assign running = (state_q != StIdle);

    pwm_period_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_period_counter (
        .clk_psc_i     (clk_psc_i),
        .rst_n_i       (rst_n_i),
        .run_i         (running),
        .clr_i         (cnt_clr),
        .ck_cnt_i      (bus.ck_cnt_i),
        .ug_i          (bus.ug_i),
        .udis_i        (bus.udis_i),
        .arpe_i        (bus.arpe_i),
        .arr_preload_i (bus.arr_preload_i),
        .cnt_o         (bus.cnt_o),
        .arr_active_o  (bus.arr_active_o),
        .overflow_o    (overflow),
        .uev_next_o    (uev_next)
    );

    always_comb begin
        state_d    = state_q;
        opm_lock_d = opm_lock_q;
        cnt_clr    = 1'b0;
        // One-pulse lockout is released only by cen_req_i going low.
        if (!bus.cen_req_i) begin
            opm_lock_d = 1'b0;
        end
        case (state_q)
            StIdle: begin
                if (bus.cen_req_i && !opm_lock_q) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!bus.cen_req_i && (bus.stop_mode_i == StopImmediate)) begin
                    state_d = StIdle;
                    cnt_clr = 1'b1;
                end else if (overflow && (bus.opm_i || !bus.cen_req_i)) begin
                    state_d    = StIdle;
                    opm_lock_d = bus.opm_i && bus.cen_req_i;
                end else if (!bus.cen_req_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (bus.cen_req_i) begin
                    state_d = StRun;
                end else if (overflow) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        uif_d = uif_q;
        if (uev_next) begin
            uif_d = 1'b1;
        end else if (bus.uif_clr_i) begin
            uif_d = 1'b0;
        end
    end

    always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StIdle;
            opm_lock_q <= 1'b0;
            uev_q      <= 1'b0;
            uif_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            opm_lock_q <= opm_lock_d;
            uev_q      <= uev_next;
            uif_q      <= uif_d;
        end
    end

    assign bus.cen_o          = running;
    assign bus.busy_o         = running;
    assign bus.update_event_o = uev_q;
    assign bus.uif_o          = uif_q;

endmodule

// File: tb/tb_pwm_timebase_ctrl.sv
// Directed self-checking bench for pwm_timebase_ctrl.
module tb_pwm_timebase_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    pwm_timebase_ctrl_if #(.CNT_WIDTH(16)) bus ();

    pwm_timebase_ctrl #(
        .CNT_WIDTH (16)
    ) dut (
        .clk_psc_i (clk),
        .rst_n_i   (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        bus.cen_req_i   = 1'b0;
        bus.stop_mode_i = 1'b0;
        bus.ug_i        = 1'b0;
        tick();
        bus.uif_clr_i = 1'b1;
        tick();
        bus.uif_clr_i = 1'b0;
    endtask

    task automatic test_reset();
        bus.cen_req_i = 0; bus.stop_mode_i = 0; bus.opm_i = 0; bus.arpe_i = 1;
        bus.udis_i = 0; bus.ug_i = 0; bus.arr_preload_i = 16'd4; bus.uif_clr_i = 0;
        bus.ck_cnt_i = 1;
        rst_n = 1'b0;
        tick(); tick();
        n_checks++; if (bus.cen_o !== 1'b0) begin n_fail++; $display("FAIL reset_cen: got %b expected 0", bus.cen_o); end
        n_checks++; if (bus.update_event_o !== 1'b0) begin n_fail++; $display("FAIL reset_uev: got %b expected 0", bus.update_event_o); end
        n_checks++; if (bus.cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", bus.cnt_o); end
        n_checks++; if (bus.arr_active_o !== 16'd0) begin n_fail++; $display("FAIL reset_arr: got %0d expected 0", bus.arr_active_o); end
        n_checks++; if (bus.uif_o !== 1'b0) begin n_fail++; $display("FAIL reset_uif: got %b expected 0", bus.uif_o); end
        n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_run();
        logic [15:0] exp_cnt;
        tick();
        n_checks++; if (bus.arr_active_o !== 16'd4) begin n_fail++; $display("FAIL basic_arr_load: got %0d expected 4", bus.arr_active_o); end
        bus.cen_req_i = 1'b1;
        n_checks++; if (bus.cen_o !== 1'b0) begin n_fail++; $display("FAIL basic_cen_before: got %b expected 0", bus.cen_o); end
        tick();
        n_checks++; if (bus.cen_o !== 1'b1) begin n_fail++; $display("FAIL basic_cen: got %b expected 1", bus.cen_o); end
        n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", bus.busy_o); end
        n_checks++; if (bus.cnt_o !== 16'd0) begin n_fail++; $display("FAIL basic_cnt_start: got %0d expected 0", bus.cnt_o); end
        for (int i = 1; i <= 5; i++) begin
            tick();
            exp_cnt = 16'(i % 5);
            n_checks++; if (bus.cnt_o !== exp_cnt) begin n_fail++; $display("FAIL basic_cnt[%0d]: got %0d expected %0d", i, bus.cnt_o, exp_cnt); end
            n_checks++; if (bus.update_event_o !== (i == 5)) begin n_fail++; $display("FAIL basic_uev[%0d]: got %b expected %b", i, bus.update_event_o, (i == 5)); end
        end
        n_checks++; if (bus.uif_o !== 1'b1) begin n_fail++; $display("FAIL basic_uif: got %b expected 1", bus.uif_o); end
        tick();
        n_checks++; if (bus.update_event_o !== 1'b0) begin n_fail++; $display("FAIL basic_uev_single: got %b expected 0", bus.update_event_o); end
        go_idle();
    endtask

    task automatic test_preload();
        bus.arpe_i = 1'b1; bus.arr_preload_i = 16'd4;
        tick();
        bus.cen_req_i = 1'b1;
        tick(); tick(); tick();
        bus.arr_preload_i = 16'd9;
        tick();
        n_checks++; if (bus.arr_active_o !== 16'd4) begin n_fail++; $display("FAIL arpe1_hold: got %0d expected 4", bus.arr_active_o); end
        tick();
        n_checks++; if (bus.cnt_o !== 16'd4) begin n_fail++; $display("FAIL arpe1_cnt4: got %0d expected 4", bus.cnt_o); end
        tick();
        n_checks++; if (bus.cnt_o !== 16'd0) begin n_fail++; $display("FAIL arpe1_wrap: got %0d expected 0", bus.cnt_o); end
        n_checks++; if (bus.arr_active_o !== 16'd9) begin n_fail++; $display("FAIL arpe1_load: got %0d expected 9", bus.arr_active_o); end
        n_checks++; if (bus.update_event_o !== 1'b1) begin n_fail++; $display("FAIL arpe1_uev: got %b expected 1", bus.update_event_o); end
        go_idle();
        bus.arpe_i = 1'b0; bus.arr_preload_i = 16'd4;
        tick();
        bus.cen_req_i = 1'b1;
        tick(); tick();
        bus.arr_preload_i = 16'd9;
        tick();
        n_checks++; if (bus.arr_active_o !== 16'd9) begin n_fail++; $display("FAIL arpe0_follow: got %0d expected 9", bus.arr_active_o); end
        for (int i = 3; i <= 9; i++) begin
            tick();
            n_checks++; if (bus.cnt_o !== 16'(i)) begin n_fail++; $display("FAIL arpe0_cnt[%0d]: got %0d expected %0d", i, bus.cnt_o, i); end
        end
        tick();
        n_checks++; if (bus.cnt_o !== 16'd0) begin n_fail++; $display("FAIL arpe0_wrap: got %0d expected 0", bus.cnt_o); end
        n_checks++; if (bus.update_event_o !== 1'b1) begin n_fail++; $display("FAIL arpe0_uev: got %b expected 1", bus.update_event_o); end
        go_idle();
        bus.arpe_i = 1'b1; bus.arr_preload_i = 16'd4;
        tick();
    endtask

    task automatic test_stop_modes();
        bus.stop_mode_i = 1'b0; bus.cen_req_i = 1'b1;
        tick(); tick(); tick();
        bus.cen_req_i = 1'b0;
        tick();
        n_checks++; if (bus.cnt_o !== 16'd0) begin n_fail++; $display("FAIL stop0_cnt: got %0d expected 0", bus.cnt_o); end
        n_checks++; if (bus.cen_o !== 1'b0) begin n_fail++; $display("FAIL stop0_cen: got %b expected 0", bus.cen_o); end
        n_checks++; if (bus.update_event_o !== 1'b0) begin n_fail++; $display("FAIL stop0_uev: got %b expected 0", bus.update_event_o); end
        tick();
        n_checks++; if (bus.update_event_o !== 1'b0) begin n_fail++; $display("FAIL stop0_uev_late: got %b expected 0", bus.update_event_o); end
        bus.stop_mode_i = 1'b1; bus.cen_req_i = 1'b1;
        tick(); tick(); tick();
        bus.cen_req_i = 1'b0;
        tick();
        n_checks++; if (bus.cnt_o !== 16'd3) begin n_fail++; $display("FAIL stop1_cnt3: got %0d expected 3", bus.cnt_o); end
        n_checks++; if (bus.cen_o !== 1'b1) begin n_fail++; $display("FAIL stop1_drain_cen: got %b expected 1", bus.cen_o); end
        tick();
        n_checks++; if (bus.cnt_o !== 16'd4) begin n_fail++; $display("FAIL stop1_cnt4: got %0d expected 4", bus.cnt_o); end
        tick();
        n_checks++; if (bus.update_event_o !== 1'b1) begin n_fail++; $display("FAIL stop1_uev: got %b expected 1", bus.update_event_o); end
        n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL stop1_idle: got %b expected 0", bus.busy_o); end
        tick();
        n_checks++; if (bus.update_event_o !== 1'b0) begin n_fail++; $display("FAIL stop1_uev_once: got %b expected 0", bus.update_event_o); end
        go_idle();
    endtask

    task automatic test_one_pulse();
        bus.opm_i = 1'b1; bus.arr_preload_i = 16'd3; bus.cen_req_i = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) tick();
        n_checks++; if (bus.cnt_o !== 16'd3) begin n_fail++; $display("FAIL opm_cnt3: got %0d expected 3", bus.cnt_o); end
        tick();
        n_checks++; if (bus.update_event_o !== 1'b1) begin n_fail++; $display("FAIL opm_uev: got %b expected 1", bus.update_event_o); end
        n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL opm_idle: got %b expected 0", bus.busy_o); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL opm_no_restart[%0d]: got %b expected 0", i, bus.busy_o); end
            n_checks++; if (bus.update_event_o !== 1'b0) begin n_fail++; $display("FAIL opm_no_uev[%0d]: got %b expected 0", i, bus.update_event_o); end
        end
        bus.cen_req_i = 1'b0;
        tick();
        bus.cen_req_i = 1'b1;
        tick();
        n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL opm_rearm: got %b expected 1", bus.busy_o); end
        bus.opm_i = 1'b0;
        go_idle();
    endtask

    task automatic test_ug_udis();
        logic [15:0] seq [7];
        seq = '{16'd1, 16'd2, 16'd0, 16'd1, 16'd2, 16'd0, 16'd1};
        bus.udis_i = 1'b1; bus.arr_preload_i = 16'd2; bus.cen_req_i = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            n_checks++; if (bus.cnt_o !== seq[i]) begin n_fail++; $display("FAIL udis_cnt[%0d]: got %0d expected %0d", i, bus.cnt_o, seq[i]); end
            n_checks++; if (bus.update_event_o !== 1'b0) begin n_fail++; $display("FAIL udis_uev[%0d]: got %b expected 0", i, bus.update_event_o); end
        end
        n_checks++; if (bus.uif_o !== 1'b0) begin n_fail++; $display("FAIL udis_uif: got %b expected 0", bus.uif_o); end
        go_idle();
        bus.udis_i = 1'b0; bus.arr_preload_i = 16'd4; bus.cen_req_i = 1'b1;
        tick(); tick(); tick();
        bus.ug_i = 1'b1;
        tick();
        bus.ug_i = 1'b0;
        n_checks++; if (bus.cnt_o !== 16'd0) begin n_fail++; $display("FAIL ug_cnt_clr: got %0d expected 0", bus.cnt_o); end
        n_checks++; if (bus.update_event_o !== 1'b1) begin n_fail++; $display("FAIL ug_uev: got %b expected 1", bus.update_event_o); end
        n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL ug_state: got %b expected 1", bus.busy_o); end
        tick();
        n_checks++; if (bus.update_event_o !== 1'b0) begin n_fail++; $display("FAIL ug_uev_once: got %b expected 0", bus.update_event_o); end
        tick(); tick(); tick();
        n_checks++; if (bus.cnt_o !== 16'd4) begin n_fail++; $display("FAIL ug_ovf_cnt4: got %0d expected 4", bus.cnt_o); end
        bus.ug_i = 1'b1;
        tick();
        bus.ug_i = 1'b0;
        n_checks++; if (bus.update_event_o !== 1'b1) begin n_fail++; $display("FAIL ug_ovf_uev: got %b expected 1", bus.update_event_o); end
        tick();
        n_checks++; if (bus.update_event_o !== 1'b0) begin n_fail++; $display("FAIL ug_ovf_once: got %b expected 0", bus.update_event_o); end
        n_checks++; if (bus.cnt_o !== 16'd1) begin n_fail++; $display("FAIL ug_ovf_cnt: got %0d expected 1", bus.cnt_o); end
    endtask

    task automatic test_flag_and_reset();
        bus.uif_clr_i = 1'b1;
        tick();
        bus.uif_clr_i = 1'b0;
        n_checks++; if (bus.uif_o !== 1'b0) begin n_fail++; $display("FAIL uif_clear: got %b expected 0", bus.uif_o); end
        bus.ug_i = 1'b1; bus.uif_clr_i = 1'b1;
        tick();
        bus.ug_i = 1'b0; bus.uif_clr_i = 1'b0;
        n_checks++; if (bus.uif_o !== 1'b1) begin n_fail++; $display("FAIL uif_set_wins: got %b expected 1", bus.uif_o); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.cen_o !== 1'b0) begin n_fail++; $display("FAIL arst_cen: got %b expected 0", bus.cen_o); end
        n_checks++; if (bus.update_event_o !== 1'b0) begin n_fail++; $display("FAIL arst_uev: got %b expected 0", bus.update_event_o); end
        n_checks++; if (bus.uif_o !== 1'b0) begin n_fail++; $display("FAIL arst_uif: got %b expected 0", bus.uif_o); end
        n_checks++; if (bus.arr_active_o !== 16'd0) begin n_fail++; $display("FAIL arst_arr: got %0d expected 0", bus.arr_active_o); end
        n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b expected 0", bus.busy_o); end
        bus.cen_req_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle: got %b expected 0", bus.busy_o); end
        n_checks++; if (bus.update_event_o !== 1'b0) begin n_fail++; $display("FAIL post_rst_uev: got %b expected 0", bus.update_event_o); end
        n_checks++; if (bus.arr_active_o !== 16'd4) begin n_fail++; $display("FAIL post_rst_arr: got %0d expected 4", bus.arr_active_o); end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_preload();
        test_stop_modes();
        test_one_pulse();
        test_ug_udis();
        test_flag_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
